// File: rtl/pmem_line_adapter_pkg.sv
// pmem_line_adapter_pkg: shared LC-3b memory types for the line adapter slice.
// Package lc3b_types provides:
//   lc3b_word            16-bit word type
//   lc3b_line            128-bit cache line type
//   LINE_BEATS           words per cache line
//   LINE_OFFSET_BITS     byte-offset bits inside a line
//   pmem_adapter_state_t line adapter FSM states
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int LINE_BEATS       = 8;
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_BEAT,
        WR_BEAT,
        DONE
    } pmem_adapter_state_t;

endpackage

// File: rtl/pmem_line_adapter_buffer.sv
// pmem_line_buffer: line-wide register file of BEATS words for the line adapter.
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset, clears every word
//   load       bulk load of load_line (write line capture)
//   load_line  full line, word 0 in the low bits
//   wr_en      single-word write of wr_word into word wr_sel
//   wr_sel     word index for wr_en
//   wr_word    word data for wr_en
//   rd_sel     word index for rd_word
//   rd_word    selected word
//   line       whole buffer contents, word 0 in the low bits
module pmem_line_buffer
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 16,
    parameter int BEATS     = LINE_BITS / WORD_BITS,
    parameter int BEAT_BITS = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [LINE_BITS-1:0] load_line,
    input  logic                 wr_en,
    input  logic [BEAT_BITS-1:0] wr_sel,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [BEAT_BITS-1:0] rd_sel,
    output logic [WORD_BITS-1:0] rd_word,
    output logic [LINE_BITS-1:0] line
);

    logic [BEATS-1:0][WORD_BITS-1:0] mem;

    always_ff @(posedge clk) begin
        if (!reset_n)
            mem <= '0;
        else if (load)
            mem <= load_line;
        else if (wr_en)
            mem[wr_sel] <= wr_word;
    end

    assign rd_word = mem[rd_sel];
    assign line    = mem;

endmodule

// File: rtl/pmem_line_adapter.sv
// pmem_line_adapter: splits whole-line pmem requests into word transactions on wmem.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   pmem_address        byte address of the requested line
//   pmem_read/write     line requests, held until pmem_resp (write wins if both)
//   pmem_wdata          line to write, word 0 in the low bits
//   pmem_rdata          last completed read line, held between reads
//   pmem_resp           one-cycle completion pulse
//   wmem_address        byte address of the current word
//   wmem_read/write     word request, held until wmem_resp
//   wmem_wdata          word write data
//   wmem_rdata          word read data, valid with wmem_resp
//   wmem_resp           word transaction complete
// Build option: PMEM_POSTED_WRITE_EN responds to writes in the first write beat
// and drains the remaining beats in the background without a DONE pulse.
module pmem_line_adapter
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 16,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] pmem_address,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic [ADDR_BITS-1:0] wmem_address,
    output logic                 wmem_read,
    output logic                 wmem_write,
    output logic [WORD_BITS-1:0] wmem_wdata,
    input  logic [WORD_BITS-1:0] wmem_rdata,
    input  logic                 wmem_resp
);

    localparam int BEATS       = LINE_BITS / WORD_BITS;
    localparam int BEAT_BITS   = $clog2(BEATS);
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int WORD_SHIFT  = $clog2(WORD_BITS / 8);
`ifdef PMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    pmem_adapter_state_t state, next_state;

    logic [BEAT_BITS-1:0] beat;
    logic [ADDR_BITS-1:0] base;
    logic [LINE_BITS-1:0] buf_line;
    logic [LINE_BITS-1:0] rd_line;
    logic [LINE_BITS-1:0] rdata_q;
    logic [WORD_BITS-1:0] buf_word;
    logic                 resp_q;
    logic                 rd_active;
    logic                 wr_active;
    logic                 beat_done;
    logic                 last_beat;
    logic                 accept;

    assign rd_active = (state == RD_BEAT);
    assign wr_active = (state == WR_BEAT);
    assign beat_done = (rd_active || wr_active) && wmem_resp;
    assign last_beat = (beat == BEAT_BITS'(BEATS - 1));
    assign accept    = (state == IDLE) && (pmem_read || pmem_write);

    // One buffer serves both directions: bulk-loaded with the write line on
    // accept, filled word by word during reads.
    pmem_line_buffer #(
        .LINE_BITS (LINE_BITS),
        .WORD_BITS (WORD_BITS)
    ) u_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      ((state == IDLE) && pmem_write),
        .load_line (pmem_wdata),
        .wr_en     (rd_active && wmem_resp),
        .wr_sel    (beat),
        .wr_word   (wmem_rdata),
        .rd_sel    (beat),
        .rd_word   (buf_word),
        .line      (buf_line)
    );

    always_comb begin
        next_state   = state;
        wmem_read    = rd_active;
        wmem_write   = wr_active;
        wmem_address = (rd_active || wr_active) ? base + (ADDR_BITS'(beat) << WORD_SHIFT) : '0;
        wmem_wdata   = wr_active ? buf_word : '0;
        // The final read word goes straight into the held read line so that
        // pmem_rdata is already valid in the DONE cycle.
        rd_line                          = buf_line;
        rd_line[LINE_BITS-1 -: WORD_BITS] = wmem_rdata;
        case (state)
            IDLE:    next_state = pmem_write ? WR_BEAT : pmem_read ? RD_BEAT : IDLE;
            RD_BEAT: next_state = (beat_done && last_beat) ? DONE : RD_BEAT;
            WR_BEAT: next_state = (beat_done && last_beat) ? (POSTED ? IDLE : DONE) : WR_BEAT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            beat    <= '0;
            base    <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            state <= next_state;
            beat  <= (state == IDLE) ? '0 : beat_done ? beat + 1'b1 : beat;
            if (accept)
                base <= pmem_address & ~ADDR_BITS'((1 << OFFSET_BITS) - 1);
            if (rd_active && beat_done && last_beat)
                rdata_q <= rd_line;
            // DONE lasts one cycle, so entering it gives a single pulse; posted
            // writes pulse in the first write-beat cycle instead.
            resp_q <= (next_state == DONE) || (POSTED && (state == IDLE) && pmem_write);
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;

endmodule
